// File: rtl/ccg_sweep_pkg.sv
// Shared types and helpers for the exhaustive sweep / MISR response checker.
// misr_next is the single definition of the Galois MISR step.
package ccg_sweep_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_DRIVE,
    ST_CAPTURE,
    ST_DONE
  } state_t;

  localparam int          DEF_N_OUT = 15;
  localparam logic [31:0] DEF_POLY  = 32'h0000_0003;  // x^15 + x + 1

  // One Galois step over the low `width` bits: shift left, fold the dropped
  // MSB back through poly, then xor in the response word.
  function automatic logic [31:0] misr_next(input logic [31:0] sig,
                                            input logic [31:0] resp,
                                            input logic [31:0] poly,
                                            input int          width = DEF_N_OUT);
    logic [31:0] mask;
    logic [31:0] shifted;
    logic        msb;
    mask    = (width >= 32) ? 32'hFFFF_FFFF : ((32'd1 << width) - 32'd1);
    msb     = ((sig >> (width - 1)) & 32'd1) != 32'd0;
    shifted = (sig << 1) & mask;
    return (shifted ^ (msb ? poly : 32'd0) ^ resp) & mask;
  endfunction

endpackage

// File: rtl/ccg_misr.sv
// WIDTH-bit Galois multiple-input signature register.
// clr takes priority over en; rst is synchronous, active-high.
module ccg_misr
  import ccg_sweep_pkg::*;
#(
  parameter int               WIDTH = 15,
  parameter logic [WIDTH-1:0] POLY  = WIDTH'(DEF_POLY)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             en,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] nxt;

  assign nxt = WIDTH'(misr_next(32'(q), 32'(d), 32'(POLY), WIDTH));

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      q <= '0;
    end else if (en) begin
      q <= nxt;
    end
  end

endmodule

// File: rtl/ccg_resp_sweep.sv
// Drives every input pattern of a combinational circuit in ascending order,
// records each response in a truth table and compacts them into a MISR signature.
module ccg_resp_sweep
  import ccg_sweep_pkg::*;
#(
  parameter int               N_IN   = 3,
  parameter int               N_OUT  = 15,
  parameter int               SETTLE = 1,
  parameter logic [N_OUT-1:0] POLY   = N_OUT'(DEF_POLY)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [N_OUT-1:0] exp_sig,
  output logic [N_IN-1:0]  dut_x,
  input  logic [N_OUT-1:0] dut_f,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [N_OUT-1:0] sig,
  input  logic [N_IN-1:0]  tt_rd_addr,
  output logic [N_OUT-1:0] tt_rd_data
);

  localparam int            DEPTH       = 1 << N_IN;
  localparam int            CW          = $clog2(SETTLE + 1);
  localparam logic [CW-1:0] SETTLE_LAST = CW'(SETTLE - 1);

  state_t           state, state_d;
  logic [N_IN-1:0]  p;
  logic [CW-1:0]    settle_cnt;
  logic             misr_clr, misr_en;
  logic             last_pat;
  logic [N_OUT-1:0] sig_next;
  logic [N_OUT-1:0] tt [DEPTH];

  assign last_pat = (p == '1);
  assign sig_next = N_OUT'(misr_next(32'(sig), 32'(dut_f), 32'(POLY), N_OUT));

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values regardless of process ordering.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_IDLE;
    end else begin
      state <= state_d;
    end
  end

  // NOTE: every output of this block is defaulted first, so no path leaves a
  // value unassigned and no latch is inferred.
  always_comb begin
    state_d  = state;
    misr_clr = 1'b0;
    misr_en  = 1'b0;
    unique case (state)
      ST_IDLE: begin
        if (start) begin
          state_d  = ST_DRIVE;
          misr_clr = 1'b1;
        end
      end
      ST_DRIVE: begin
        if (settle_cnt == SETTLE_LAST) state_d = ST_CAPTURE;
      end
      ST_CAPTURE: begin
        misr_en = 1'b1;
        state_d = last_pat ? ST_DONE : ST_DRIVE;
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      p          <= '0;
      settle_cnt <= '0;
      pass       <= 1'b0;
    end else begin
      unique case (state)
        ST_IDLE: begin
          if (start) begin
            p          <= '0;
            settle_cnt <= '0;
            pass       <= 1'b0;
          end
        end
        ST_DRIVE: settle_cnt <= settle_cnt + CW'(1);
        ST_CAPTURE: begin
          settle_cnt <= '0;
          // The last pattern exits to DONE instead of wrapping p.
          if (last_pat) pass <= (sig_next == exp_sig);
          else          p    <= p + N_IN'(1);
        end
        default: ;
      endcase
    end
  end

  ccg_misr #(
    .WIDTH (N_OUT),
    .POLY  (POLY)
  ) u_misr (
    .clk (clk),
    .rst (rst),
    .clr (misr_clr),
    .en  (misr_en),
    .d   (dut_f),
    .q   (sig)
  );

  // NOTE: the truth-table array has no reset; its contents are only meaningful
  // after a sweep writes them, and leaving it unreset lets it map onto RAM.
  always_ff @(posedge clk) begin
    if (!rst && state == ST_CAPTURE) tt[p] <= dut_f;
  end

  // Same-cycle read of the word being captured returns the previous contents.
  always_ff @(posedge clk) begin
    if (rst) tt_rd_data <= '0;
    else     tt_rd_data <= tt[tt_rd_addr];
  end

  assign dut_x = p;
  assign busy  = (state == ST_DRIVE) || (state == ST_CAPTURE);
  assign done  = (state == ST_DONE);

endmodule
